// File: rtl/fifo_reader.sv
// Pops a burst of words from an upstream FIFO into a 2-entry skid buffer and streams them out with a last tag.
// Latency: one cycle from pop to out_valid when the buffer is empty; pops pause while the buffer is full.
module fifo_reader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  burst_len,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [4:0]  word_count,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  remaining;
  logic [1:0]  occ;
  logic [1:0]  occ_next;
  logic        head;
  logic        tail;
  logic [31:0] ent_data [2];
  logic        ent_last [2];
  logic        retire;

  // Pop decision uses only registered occupancy, so it never waits on out_ready.
  assign fifo_rd   = (state == ST_DRAIN) && !fifo_empty && (remaining != 5'd0) && (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? ent_data[head] : 32'd0;
  assign out_last  = out_valid & ent_last[head];
  assign retire    = out_valid & out_ready;
  assign tail      = head ^ occ[0];

  always_comb begin
    occ_next = occ + {1'b0, fifo_rd} - {1'b0, retire};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      remaining   <= 5'd0;
      occ         <= 2'd0;
      head        <= 1'b0;
      ent_data[0] <= 32'd0;
      ent_data[1] <= 32'd0;
      ent_last[0] <= 1'b0;
      ent_last[1] <= 1'b0;
      word_count  <= 5'd0;
      checksum    <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      occ <= occ_next;
      if (retire) begin
        head <= ~head;
      end
      if (fifo_rd) begin
        ent_data[tail] <= fifo_data;
        ent_last[tail] <= (remaining == 5'd1);
        remaining      <= remaining - 5'd1;
        word_count     <= word_count + 5'd1;
        checksum       <= checksum + fifo_data;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining  <= (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
            word_count <= 5'd0;
            checksum   <= 32'd0;
            state      <= ST_DRAIN;
            busy       <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_rd && (remaining == 5'd1)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Leave as soon as the final retire empties the buffer.
          if (occ_next == 2'd0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: an upstream FIFO model feeds the DUT, popped words are queued as expectations.
module tb_fifo_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  burst_len = 4'd0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = 32'd0;
  logic        fifo_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [4:0]  word_count;
  logic [31:0] checksum;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fq [$];
  logic [32:0] exp_q [$];
  bit          hold_empty = 1'b0;
  bit          m_idle = 1'b1;
  int          m_rem = 0;
  int          m_cnt = 0;
  logic [31:0] m_sum = 32'd0;
  int          pop_cnt = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;

  fifo_reader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = hold_empty || (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: sample pre-edge outputs, score them, advance the FIFO model, return at the next negedge.
  task automatic tick();
    bit          rd;
    logic [32:0] e;
    #1;
    rd = fifo_rd;
    chk("rd_while_empty", {31'd0, fifo_rd & fifo_empty}, 32'd0);
    if (fifo_rd) begin
      exp_q.push_back({(m_rem == 1), fifo_data});
      m_rem--;
      m_cnt++;
      m_sum += fifo_data;
      pop_cnt++;
    end
    if (done) begin
      done_cnt++;
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_last", {31'd0, out_last}, {31'd0, e[32]});
      end
    end
    if (!reset_n) begin
      m_idle = 1'b1;
      m_rem  = 0;
      exp_q.delete();
    end else if (start && m_idle) begin
      m_idle = 1'b0;
      m_rem  = (burst_len == 4'd0) ? 16 : int'(burst_len);
      m_cnt  = 0;
      m_sum  = 32'd0;
    end else if (done) begin
      m_idle = 1'b1;
    end
    @(posedge clock);
    #1;
    if (rd && fq.size() != 0) begin
      void'(fq.pop_front());
    end
    refresh();
    @(negedge clock);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    int d0;
    d0 = done_cnt;
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end
    chk("done_pulses", done_cnt - d0, 32'd1);
  endtask

  task automatic end_check(input string tag, input int n, input logic [31:0] sum);
    chk({tag, "_word_count"}, {27'd0, word_count}, n);
    chk({tag, "_checksum"}, checksum, sum);
    chk({tag, "_model_count"}, m_cnt, n);
    chk({tag, "_model_sum"}, m_sum, sum);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic start_burst(input logic [3:0] len);
    burst_len = len;
    start     = 1'b1;
    pop_cnt   = 0;
    out_cnt   = 0;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int cyc;
    int d0;
    refresh();
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_word_count", {27'd0, word_count}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);

    // Basic three-word burst, consumer always ready.
    fq = '{32'hA, 32'hB, 32'hC};
    refresh();
    out_ready = 1'b1;
    start_burst(4'd3);
    wait_done(50, cyc);
    chk("b3_cycles", cyc, 32'd5);
    chk("b3_outputs", out_cnt, 32'd3);
    end_check("b3", 3, 32'h21);

    // Consumer stalled: only the burst's two words may be popped, head word held.
    fq = '{32'h100, 32'h101, 32'h102, 32'h103};
    refresh();
    out_ready = 1'b0;
    start_burst(4'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'h100);
    end
    chk("stall_pops", pop_cnt, 32'd2);
    chk("stall_rd_low", {31'd0, fifo_rd}, 32'd0);
    chk("stall_fifo_left", fq.size(), 32'd2);
    out_ready = 1'b1;
    wait_done(50, cyc);
    end_check("b2", 2, 32'h201);
    fq.delete();
    refresh();

    // Upstream empty for six cycles after start.
    hold_empty = 1'b1;
    fq = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0001};
    refresh();
    start_burst(4'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("empty_busy", {31'd0, busy}, 32'd1);
      chk("empty_rd", {31'd0, fifo_rd}, 32'd0);
      chk("empty_count", {27'd0, word_count}, 32'd0);
    end
    chk("empty_pops", pop_cnt, 32'd0);
    hold_empty = 1'b0;
    refresh();
    wait_done(50, cyc);
    end_check("b4", 4, 32'hAAAA_0001);

    // burst_len 0 means 16 words; checksum wraps.
    for (int i = 0; i < 20; i++) fq.push_back(32'hFFFF_FFFF);
    refresh();
    start_burst(4'd0);
    wait_done(100, cyc);
    chk("b16_outputs", out_cnt, 32'd16);
    chk("b16_fifo_left", fq.size(), 32'd4);
    end_check("b16", 16, 32'hFFFF_FFF0);
    fq.delete();
    refresh();

    // Reset after two of four words are popped.
    fq = '{32'h5, 32'h6, 32'h7, 32'h8};
    refresh();
    out_ready = 1'b0;
    start_burst(4'd4);
    tick();
    tick();
    chk("mid_pops", pop_cnt, 32'd2);
    chk("mid_count", {27'd0, word_count}, 32'd2);
    d0 = done_cnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {27'd0, word_count}, 32'd0);
    chk("mid_rst_checksum", checksum, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_done", done_cnt - d0, 32'd0);
    chk("mid_rst_no_out", out_cnt, 32'd0);
    fq.delete();
    refresh();

    // start during DRAIN and DONE is ignored; a later start runs a fresh burst.
    fq = '{32'h10, 32'h20, 32'h30};
    refresh();
    start_burst(4'd3);
    burst_len = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("ign_reached_done", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_idle", {31'd0, busy}, 32'd0);
    chk("ign_pops", pop_cnt, 32'd3);
    end_check("ign", 3, 32'h60);
    fq = '{32'h7, 32'h9};
    refresh();
    start_burst(4'd2);
    chk("fresh_cleared_count", {27'd0, word_count}, 32'd0);
    chk("fresh_cleared_sum", checksum, 32'd0);
    wait_done(50, cyc);
    end_check("fresh", 2, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  begin a burst; sampled only in IDLE.
REQ-004 SHALL have port: burst_len  input  4  words per burst, sampled with start; 0 means 16.
REQ-005 SHALL have port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 SHALL have port: fifo_data  input  32  upstream FIFO head word, valid whenever fifo_empty=0.
REQ-007 SHALL have port: fifo_rd  output  1  pop strobe to upstream FIFO.
REQ-008 SHALL have port: out_valid  output  1  downstream word available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts word this cycle.
REQ-010 SHALL have port: out_data  output  32  downstream word.
REQ-011 SHALL have port: out_last  output  1  marks final word of burst, qualified by out_valid.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse at burst completion.
REQ-014 SHALL have port: word_count  output  5  words popped from FIFO in current burst.
REQ-015 SHALL have port: checksum  output  32  modulo-2^32 sum of words popped in current burst.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, FLUSH, DONE.
REQ-017 SHALL, in IDLE with start=1, latch remaining=burst_len (0->16), clear word_count and checksum, and enter DRAIN next cycle.
REQ-018 SHALL ignore start in DRAIN, FLUSH, DONE.
REQ-019 SHALL hold a 2-entry output buffer; each entry stores 32-bit data plus a last tag.
REQ-020 SHALL assert fifo_rd combinationally iff state=DRAIN, fifo_empty=0, remaining>0, and buffer occupancy <2 (registered occupancy; no dependence on out_ready).
REQ-021 SHALL, on a cycle with fifo_rd=1, capture fifo_data into the buffer at the clock edge, decrement remaining, increment word_count, add fifo_data to checksum (carry discarded).
REQ-022 SHALL tag the captured word last=1 when remaining=1 at capture.
REQ-023 SHALL present a captured word on out_valid/out_data/out_last no earlier than the cycle after capture (one-cycle latency when buffer was empty).
REQ-024 SHALL drive out_valid=1 whenever buffer occupancy >0, out_data/out_last from the oldest entry, preserving FIFO order.
REQ-025 SHALL retire the oldest entry on a cycle where out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 SHALL support capture and retire in the same cycle with occupancy unchanged.
REQ-027 SHALL transition DRAIN->FLUSH on the edge where remaining becomes 0.
REQ-028 SHALL transition FLUSH->DONE when occupancy is 0 (including same edge the last word retires: DONE entered the following cycle at latest).
REQ-029 SHALL assert done=1 only in DONE, remain in DONE exactly one cycle, then return to IDLE.
REQ-030 SHALL hold word_count and checksum stable from DONE until the next accepted start.
REQ-031 SHALL stall in DRAIN indefinitely while fifo_empty=1, with fifo_rd=0 and no counter change.
REQ-032 SHALL never assert fifo_rd outside DRAIN nor when fifo_empty=1.

Reset
REQ-033 SHALL, when reset_n=0 at a rising edge, set state=IDLE, remaining=0, occupancy=0, word_count=0, checksum=0.
REQ-034 SHALL produce after reset: fifo_rd=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-035 SHALL, on reset mid-burst, discard buffered words and not pulse done.

Verification
REQ-036 SHALL cover: FIFO holds 0xA,0xB,0xC; start, burst_len=3, out_ready=1 -> out_data A,B,C on consecutive cycles, out_last only on C, word_count=3, checksum=0x21, single done pulse.
REQ-037 SHALL cover: burst_len=2, out_ready=0 for 5 cycles, FIFO holds 4 words -> exactly 2 pops, fifo_rd low thereafter, out_data stable at first word until out_ready rises.
REQ-038 SHALL cover: burst_len=4, fifo_empty=1 for 6 cycles after start then 4 words arrive -> busy held, no pops during empty, burst completes with word_count=4.
REQ-039 SHALL cover: burst_len=0 with 16 words 0xFFFFFFFF -> 16 outputs, word_count=16, checksum=0xFFFFFFF0.
REQ-040 SHALL cover: reset_n=0 after 2 of 4 words popped -> next cycle out_valid=0, busy=0, word_count=0, no done pulse.
REQ-041 SHALL cover: start pulsed during DRAIN and DONE -> ignored; second start in IDLE after done runs a fresh burst with counters cleared.
